// File: rtl/pipe_stage_hs.sv
// Valid/ready pipeline stage with a main register and an optional skid register.
// Define PIPE_STAGE_HS_SKID_EN to build the skid register; otherwise a single-entry stage.
module pipe_stage_hs #(
    parameter int unsigned            WIDTH      = 96,
    parameter logic [WIDTH-1:0]       BUBBLE_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);

    logic             m_valid, m_valid_n;
    logic [WIDTH-1:0] m_data, m_data_n;
    logic             accept, consume;

    assign consume   = m_valid && out_ready && en;
    assign accept    = in_valid && in_ready;
    assign out_valid = m_valid;
    assign out_data  = m_data;

`ifdef PIPE_STAGE_HS_SKID_EN
    logic             s_valid, s_valid_n;
    logic [WIDTH-1:0] s_data, s_data_n;
    logic [1:0]       occ_q;

    // in_ready deliberately ignores out_ready so upstream sees a registered-only path
    assign in_ready  = en && !s_valid;
    assign occupancy = occ_q;

    always_comb begin
        m_valid_n = m_valid;
        m_data_n  = m_data;
        s_valid_n = s_valid;
        s_data_n  = s_data;
        if (consume) begin
            if (s_valid) begin
                m_data_n  = s_data;
                s_valid_n = 1'b0;
            end else if (accept) begin
                m_data_n  = in_data;
            end else begin
                m_valid_n = 1'b0;
            end
        end else if (accept) begin
            if (!m_valid) begin
                m_valid_n = 1'b1;
                m_data_n  = in_data;
            end else begin
                s_valid_n = 1'b1;
                s_data_n  = in_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            m_valid <= 1'b0;
            m_data  <= BUBBLE_VAL;
            s_valid <= 1'b0;
            s_data  <= BUBBLE_VAL;
            occ_q   <= '0;
        end else begin
            m_valid <= m_valid_n;
            m_data  <= m_data_n;
            s_valid <= s_valid_n;
            s_data  <= s_data_n;
            occ_q   <= {1'b0, m_valid_n} + {1'b0, s_valid_n};
        end
    end
`else
    assign in_ready  = en && (!m_valid || out_ready);
    assign occupancy = {1'b0, m_valid};

    always_comb begin
        m_valid_n = m_valid;
        m_data_n  = m_data;
        if (accept) begin
            m_valid_n = 1'b1;
            m_data_n  = in_data;
        end else if (consume) begin
            m_valid_n = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            m_valid <= 1'b0;
            m_data  <= BUBBLE_VAL;
        end else begin
            m_valid <= m_valid_n;
            m_data  <= m_data_n;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Directed self-checking bench for pipe_stage_hs; follows PIPE_STAGE_HS_SKID_EN like the RTL.
module tb_pipe_stage_hs;

    localparam int unsigned W = 96;

    logic         clk = 1'b0;
    logic         reset, en, flush, in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0] in_data, out_data;
    logic [1:0]   occupancy;
    int           checks = 0;
    int           failures = 0;

    pipe_stage_hs #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .en(en), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Inline comparison of the three registered outputs at one point in a scenario
    task automatic test_reset();
        reset = 1'b0; en = 1'b1; flush = 1'b0; out_ready = 1'b0;
        in_valid = 1'b1; in_data = 96'hA;
        tick(); tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== '0) begin failures++; $display("FAIL reset_data got=%h exp=0", out_data); end
        checks++; if (occupancy !== 2'd0) begin failures++; $display("FAIL reset_occ got=%0d exp=0", occupancy); end
        reset = 1'b1; in_valid = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_inready got=%b exp=1", in_ready); end
    endtask

    task automatic test_pass_through();
        logic [W-1:0] v;
        en = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            v = W'(i);
            in_data = v;
            tick();
            checks++; if (out_data !== v || out_valid !== 1'b1) begin failures++; $display("FAIL pass_data%0d got=%h/%b exp=%h/1", i, out_data, out_valid, v); end
            checks++; if (occupancy !== 2'd1) begin failures++; $display("FAIL pass_occ%0d got=%0d exp=1", i, occupancy); end
        end
        in_valid = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin failures++; $display("FAIL pass_drain got=%b/%0d exp=0/0", out_valid, occupancy); end
        checks++; if (out_data !== 96'h3) begin failures++; $display("FAIL pass_hold got=%h exp=3", out_data); end
    endtask

`ifdef PIPE_STAGE_HS_SKID_EN
    task automatic fill_two();
        en = 1'b1; out_ready = 1'b0; in_valid = 1'b1;
        in_data = 96'h10; tick();
        in_data = 96'h11; tick();
        in_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        fill_two();
        checks++; if (occupancy !== 2'd2 || in_ready !== 1'b0) begin failures++; $display("FAIL bp_full got=%0d/%b exp=2/0", occupancy, in_ready); end
        in_valid = 1'b1; in_data = 96'h12;
        tick();
        checks++; if (out_data !== 96'h10 || occupancy !== 2'd2) begin failures++; $display("FAIL bp_hold got=%h/%0d exp=10/2", out_data, occupancy); end
        out_ready = 1'b1;
        tick();
        checks++; if (out_data !== 96'h11 || occupancy !== 2'd1 || in_ready !== 1'b1) begin failures++; $display("FAIL bp_d1 got=%h/%0d/%b exp=11/1/1", out_data, occupancy, in_ready); end
        tick();
        checks++; if (out_data !== 96'h12 || out_valid !== 1'b1 || occupancy !== 2'd1) begin failures++; $display("FAIL bp_d2 got=%h/%b/%0d exp=12/1/1", out_data, out_valid, occupancy); end
        in_valid = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin failures++; $display("FAIL bp_empty got=%b/%0d exp=0/0", out_valid, occupancy); end
    endtask

    task automatic test_stall();
        fill_two();
        en = 1'b0; out_ready = 1'b1; in_valid = 1'b1; in_data = 96'h55;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (out_data !== 96'h10 || occupancy !== 2'd2 || in_ready !== 1'b0) begin failures++; $display("FAIL stall%0d got=%h/%0d/%b exp=10/2/0", i, out_data, occupancy, in_ready); end
        end
        en = 1'b1; in_valid = 1'b0;
        tick();
        checks++; if (out_data !== 96'h11 || occupancy !== 2'd1) begin failures++; $display("FAIL stall_res1 got=%h/%0d exp=11/1", out_data, occupancy); end
        tick();
        checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin failures++; $display("FAIL stall_res2 got=%b/%0d exp=0/0", out_valid, occupancy); end
    endtask

    task automatic test_flush();
        fill_two();
        flush = 1'b1; in_valid = 1'b1; in_data = 96'h20; en = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0 || out_data !== '0 || occupancy !== 2'd0) begin failures++; $display("FAIL flush got=%b/%h/%0d exp=0/0/0", out_valid, out_data, occupancy); end
        flush = 1'b0; in_valid = 1'b0; en = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (out_valid !== 1'b0 || out_data === 96'h20) begin failures++; $display("FAIL flush_after%0d got=%b/%h exp=0/not20", i, out_valid, out_data); end
        end
    endtask

    task automatic test_reset_mid();
        fill_two();
        reset = 1'b0; in_valid = 1'b1; in_data = 96'h77; out_ready = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0 || out_data !== '0 || occupancy !== 2'd0) begin failures++; $display("FAIL rst_mid got=%b/%h/%0d exp=0/0/0", out_valid, out_data, occupancy); end
        reset = 1'b1; in_valid = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL rst_mid_rel got=%b/%b exp=0/1", out_valid, in_ready); end
    endtask
`else
    task automatic fill_one();
        en = 1'b1; out_ready = 1'b0; in_valid = 1'b1;
        in_data = 96'h10; tick();
        in_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        fill_one();
        checks++; if (occupancy !== 2'd1 || in_ready !== 1'b0) begin failures++; $display("FAIL bp_full got=%0d/%b exp=1/0", occupancy, in_ready); end
        in_valid = 1'b1; in_data = 96'h11;
        tick();
        checks++; if (out_data !== 96'h10 || occupancy !== 2'd1) begin failures++; $display("FAIL bp_hold got=%h/%0d exp=10/1", out_data, occupancy); end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_comb got=%b exp=1", in_ready); end
        tick();
        checks++; if (out_data !== 96'h11 || out_valid !== 1'b1 || occupancy !== 2'd1) begin failures++; $display("FAIL bp_repl got=%h/%b/%0d exp=11/1/1", out_data, out_valid, occupancy); end
        in_valid = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin failures++; $display("FAIL bp_empty got=%b/%0d exp=0/0", out_valid, occupancy); end
    endtask

    task automatic test_stall();
        fill_one();
        en = 1'b0; out_ready = 1'b1; in_valid = 1'b1; in_data = 96'h55;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (out_data !== 96'h10 || occupancy !== 2'd1 || in_ready !== 1'b0) begin failures++; $display("FAIL stall%0d got=%h/%0d/%b exp=10/1/0", i, out_data, occupancy, in_ready); end
        end
        en = 1'b1; in_valid = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin failures++; $display("FAIL stall_res got=%b/%0d exp=0/0", out_valid, occupancy); end
    endtask

    task automatic test_flush();
        fill_one();
        flush = 1'b1; in_valid = 1'b1; in_data = 96'h20; en = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0 || out_data !== '0 || occupancy !== 2'd0) begin failures++; $display("FAIL flush got=%b/%h/%0d exp=0/0/0", out_valid, out_data, occupancy); end
        flush = 1'b0; in_valid = 1'b0; en = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (out_valid !== 1'b0 || out_data === 96'h20) begin failures++; $display("FAIL flush_after%0d got=%b/%h exp=0/not20", i, out_valid, out_data); end
        end
    endtask

    task automatic test_reset_mid();
        fill_one();
        reset = 1'b0; in_valid = 1'b1; in_data = 96'h77; out_ready = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0 || out_data !== '0 || occupancy !== 2'd0) begin failures++; $display("FAIL rst_mid got=%b/%h/%0d exp=0/0/0", out_valid, out_data, occupancy); end
        reset = 1'b1; in_valid = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL rst_mid_rel got=%b/%b exp=0/1", out_valid, in_ready); end
    endtask
`endif

    initial begin
        test_reset();
        test_pass_through();
        test_backpressure();
        test_stall();
        test_flush();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_stage_hs.md
PIPE_STAGE_HS -- requirements
Module: pipe_stage_hs

Interface
REQ-001 Parameter WIDTH, default 96, payload width in bits (Instr+PC+PCPlus4 = 3x32).
REQ-002 Parameter BUBBLE_VAL, default {WIDTH{1'b0}}, payload value loaded on reset/flush.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-low reset (asserted when 0).
REQ-005 en  input  1  global stage enable; 0 freezes all handshake transfers.
REQ-006 flush  input  1  squash all held entries (bubble insert).
REQ-007 in_valid  input  1  upstream has payload.
REQ-008 in_ready  output  1  stage accepts payload this cycle.
REQ-009 in_data  input  WIDTH  upstream payload.
REQ-010 out_valid  output  1  out_data holds a valid entry.
REQ-011 out_ready  input  1  downstream consumes this cycle.
REQ-012 out_data  output  WIDTH  head entry payload.
REQ-013 occupancy  output  2  entries held, 0..2.

Function
REQ-014 Accept = in_valid && in_ready; consume = out_valid && out_ready && en; both evaluated at posedge clk.
REQ-015 Storage: main register M (drives out_data/out_valid) plus skid register S; strict FIFO order M before S.
REQ-016 in_ready = en && !S_valid; combinational from registered state and en only, never from out_ready.
REQ-017 Accept with M empty, or M consumed same cycle and S empty: in_data -> M; latency 1 cycle in_data to out_data.
REQ-018 Accept with M held and not consumed: in_data -> S; occupancy becomes 2, in_ready drops next cycle.
REQ-019 Consume with S full: S -> M, S empties; in_ready returns next cycle.
REQ-020 Consume with S empty, no accept: M_valid clears; out_data holds last value.
REQ-021 en=0: M, S, out_data, occupancy all hold; in_ready=0; consume suppressed regardless of out_ready.
REQ-022 flush=1 (regardless of en, in_valid, out_ready): next cycle M_valid=S_valid=0, out_data=BUBBLE_VAL, occupancy=0; same-cycle accept is discarded.
REQ-023 Priority: reset > flush > en gating > accept/consume.
REQ-024 occupancy = M_valid + S_valid, registered, never exceeds 2; no entry lost or duplicated.
REQ-025 Full throughput: in_valid=out_ready=en=1 continuously moves one entry per cycle with occupancy steady at 1.

Reset
REQ-026 reset=0 at posedge clk: out_valid=0, S_valid=0, out_data=BUBBLE_VAL, S payload=BUBBLE_VAL, occupancy=0.
REQ-027 Reset mid-operation discards all held entries; in_data ignored that cycle.
REQ-028 First cycle after reset release: in_ready=en.

Configuration
REQ-029 Macro PIPE_STAGE_HS_SKID_EN defined: S register present, behaviour REQ-015..REQ-025 as written.
REQ-030 Macro undefined: no S register; in_ready = en && (!out_valid || out_ready) (combinational through out_ready); occupancy max 1, bit 1 tied 0; reset/flush/en rules unchanged.

Verification
REQ-031 Reset: reset=0 two cycles with in_valid=1, in_data=96'hA -> out_valid=0, out_data=0, occupancy=0; release, en=1 -> in_ready=1.
REQ-032 Pass-through: en=1, out_ready=1, in_data 96'h1,2,3 on consecutive cycles -> out_data 1,2,3 one cycle later each, occupancy=1 throughout.
REQ-033 Backpressure (SKID_EN): out_ready=0, send 96'h10,96'h11 -> occupancy=2, in_ready=0, 96'h12 held upstream; out_ready=1 -> 10,11,12 emerge in order, none lost.
REQ-034 Stall: occupancy=2, en=0 with out_ready=1 for 3 cycles -> out_data=96'h10 stable, occupancy=2, in_ready=0; en=1 resumes drain.
REQ-035 Flush collision: occupancy=2, flush=1 with in_valid=1, in_data=96'h20 -> next cycle out_valid=0, out_data=BUBBLE_VAL, occupancy=0; 96'h20 never appears.
REQ-036 No-skid build: macro undefined, out_ready=0 with entry held -> in_ready=0 same cycle; out_ready=1 with in_valid=1 -> replace in one cycle, occupancy stays 1.
